// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer test-pattern writer.
// PATTERN_ANIM_EN (optional) enables the per-frame horizontal pattern scroll.
package fb_pkg;

    localparam int unsigned HDISP_DEF = 800;
    localparam int unsigned VDISP_DEF = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        YIELD,
        DONE
    } wr_state_t;

    localparam rgb_t WHITE = 24'hFF_FFFF;

    // Framebuffer word layout: {8'h00, R, G, B}
    function automatic logic [31:0] pack_pixel(input rgb_t px);
        return {8'h00, px};
    endfunction

endpackage

// File: rtl/fb_pattern_gen.sv
// Combinational test-pattern source: white grid lines over an x/y colour ramp.
// Under PATTERN_ANIM_EN the caller feeds a live frame counter, else it is tied to zero.
module fb_pattern_gen
    import fb_pkg::*;
#(
    parameter int unsigned HDISP = HDISP_DEF,
    parameter int unsigned GRID  = 16,
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 9
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [7:0]    frame_cnt_i,
    output rgb_t          pix_o
);

    logic [31:0] xs;
    logic [31:0] ys;
    logic        on_grid;

    // Shifted column wraps within the line; GRID is a power of two so a mask tests the pitch
    always_comb begin
        xs      = (32'(x_i) + 32'(frame_cnt_i)) % 32'(HDISP);
        ys      = 32'(y_i);
        on_grid = ((xs & 32'(GRID - 1)) == 32'd0) || ((ys & 32'(GRID - 1)) == 32'd0);
        if (on_grid) begin
            pix_o = WHITE;
        end else begin
            pix_o = '{r: xs[7:0], g: ys[7:0], b: 8'h80};
        end
    end

endmodule

// File: rtl/fb_pattern_writer.sv
// Wishbone master that fills the SDRAM framebuffer with a test pattern, yielding the bus periodically.
// Optional macro PATTERN_ANIM_EN adds a frame counter that scrolls the pattern one pixel per frame.
module fb_pattern_writer
    import fb_pkg::*;
#(
    parameter int unsigned HDISP     = HDISP_DEF,
    parameter int unsigned VDISP     = VDISP_DEF,
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned GRID      = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic [31:0] wshb_adr_o,
    output logic [31:0] wshb_dat_o,
    output logic [3:0]  wshb_sel_o,
    output logic        wshb_we_o,
    output logic        wshb_cyc_o,
    output logic        wshb_stb_o,
    output logic [2:0]  wshb_cti_o,
    output logic [1:0]  wshb_bte_o,
    input  logic        wshb_ack_i,
    input  logic        wshb_err_i,
    input  logic        wshb_rty_i,
    output logic        busy,
    output logic        frame_done,
    output logic        error
);

    localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);

    wr_state_t   state_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] burst_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        cyc_q, stb_q, we_q;
    logic        busy_q, done_q, error_q;
    logic [7:0]  frame_cnt;
    rgb_t        pix_d;
    logic        last_px;
    logic        burst_end;

    // Raster position of the word that follows the current one; origin while idle
    always_comb begin
        x_d = x_q + XW'(1);
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
        end
        if (state_q == IDLE) begin
            x_d = '0;
            y_d = '0;
        end
    end

    assign last_px   = (x_q == X_LAST) && (y_q == Y_LAST);
    assign burst_end = (burst_q == B_LAST);

    fb_pattern_gen #(
        .HDISP (HDISP),
        .GRID  (GRID),
        .XW    (XW),
        .YW    (YW)
    ) u_gen (
        .x_i         (x_d),
        .y_i         (y_d),
        .frame_cnt_i (frame_cnt),
        .pix_o       (pix_d)
    );

`ifdef PATTERN_ANIM_EN
    logic [7:0] frame_cnt_q;

    // Counts completed frames; wraps naturally at 256
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            frame_cnt_q <= 8'd0;
        end else if (state_q == WRITE && wshb_ack_i && !wshb_err_i && last_px) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            burst_q <= '0;
            adr_q   <= BASE_ADR;
            dat_q   <= 32'd0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WRITE;
                        x_q     <= '0;
                        y_q     <= '0;
                        burst_q <= '0;
                        adr_q   <= BASE_ADR;
                        dat_q   <= pack_pixel(pix_d);
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                    end
                end
                WRITE: begin
                    // err has priority over ack, ack over rty
                    if (wshb_err_i) begin
                        state_q <= DONE;
                        error_q <= 1'b1;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (wshb_ack_i) begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        burst_q <= burst_q + BW'(1);
                        adr_q   <= adr_q + 32'd4;
                        dat_q   <= pack_pixel(pix_d);
                        if (last_px) begin
                            state_q <= DONE;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            we_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (burst_end) begin
                            state_q <= YIELD;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            we_q    <= 1'b0;
                        end
                    end else if (wshb_rty_i) begin
                        state_q <= YIELD;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                    end
                end
                YIELD: begin
                    state_q <= WRITE;
                    burst_q <= '0;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    we_q    <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wshb_adr_o = adr_q;
    assign wshb_dat_o = dat_q;
    assign wshb_sel_o = 4'hF;
    assign wshb_we_o  = we_q;
    assign wshb_cyc_o = cyc_q;
    assign wshb_stb_o = stb_q;
    assign wshb_cti_o = 3'b000;
    assign wshb_bte_o = 2'b00;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed bench for fb_pattern_writer on a small 8x4 frame with a scripted Wishbone slave.
module tb_fb_pattern_writer;

    localparam int unsigned HD   = 8;
    localparam int unsigned VD   = 4;
    localparam int unsigned GR   = 4;
    localparam int unsigned BL   = 4;
    localparam logic [31:0] BASE = 32'h100;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start     = 1'b0;
    logic        ack       = 1'b0;
    logic        err       = 1'b0;
    logic        rty       = 1'b0;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        busy, frame_done, error;

    int checks   = 0;
    int failures = 0;

    int          n_ack, gap_cyc, bad_gap, bad_adr, bad_stable, extra;
    logic        first_ok, err_at_start, fin_done, fin_error, fin_cyc, timed_out, rty_ok;
    logic [31:0] last_adr;
    logic [31:0] dats [32];

    always #5 sys_clk = ~sys_clk;

    fb_pattern_writer #(
        .HDISP     (HD),
        .VDISP     (VD),
        .BASE_ADR  (BASE),
        .BURST_LEN (BL),
        .GRID      (GR)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .wshb_adr_o (adr),
        .wshb_dat_o (dat),
        .wshb_sel_o (sel),
        .wshb_we_o  (we),
        .wshb_cyc_o (cyc),
        .wshb_stb_o (stb),
        .wshb_cti_o (cti),
        .wshb_bte_o (bte),
        .wshb_ack_i (ack),
        .wshb_err_i (err),
        .wshb_rty_i (rty),
        .busy       (busy),
        .frame_done (frame_done),
        .error      (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then act as a slave cycle by cycle until the writer drops busy
    task automatic run_frame(input int waits, input logic [31:0] rty_at,
                             input logic [31:0] err_at, input int restart_at);
        int   wcnt = 0;
        int   run = 0;
        int   rty_phase = 0;
        bit   rty_fired = 0;
        bit   pend = 0;
        bit   finished = 0;
        logic [31:0] padr = '0;
        logic [31:0] pdat = '0;
        n_ack = 0; gap_cyc = 0; bad_gap = 0; bad_adr = 0; bad_stable = 0; extra = 0;
        rty_ok = 1'b0; last_adr = '0;
        for (int i = 0; i < 32; i++) dats[i] = '0;
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        first_ok     = cyc && stb && we && (adr == BASE);
        err_at_start = error;
        for (int c = 0; c < 600; c++) begin
            ack = 1'b0; err = 1'b0; rty = 1'b0;
            start = (c == restart_at);
            if (!busy) begin
                finished = 1;
                break;
            end
            if (rty_phase == 1) begin
                rty_ok = !cyc;
                rty_phase = 2;
            end else if (rty_phase == 2) begin
                rty_ok = rty_ok && cyc && (adr == rty_at);
                rty_phase = 3;
            end
            if (cyc && stb) begin
                run = 0;
                if (pend && (adr !== padr || dat !== pdat)) bad_stable++;
                if (wcnt < waits) begin
                    wcnt++;
                    pend = 1; padr = adr; pdat = dat;
                end else begin
                    wcnt = 0;
                    pend = 0;
                    if (adr == err_at) begin
                        err = 1'b1;
                    end else if (adr == rty_at && !rty_fired) begin
                        rty = 1'b1; rty_fired = 1; rty_phase = 1;
                    end else begin
                        ack = 1'b1;
                        if (adr !== BASE + 32'(4 * n_ack)) bad_adr++;
                        if (n_ack < 32) dats[n_ack] = dat;
                        last_adr = adr;
                        n_ack++;
                    end
                end
            end else begin
                pend = 0;
                run++;
                gap_cyc++;
                if (run > 1 || (n_ack % BL) != 0) bad_gap++;
            end
            @(negedge sys_clk);
        end
        ack = 1'b0; err = 1'b0; rty = 1'b0; start = 1'b0;
        timed_out = !finished;
        fin_done  = frame_done;
        fin_error = error;
        fin_cyc   = cyc;
        repeat (2) begin
            @(negedge sys_clk);
            if (frame_done || cyc || busy) extra++;
        end
    endtask

    initial begin
        // Reset state
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_cyc",   32'(cyc), 32'd0);
        check("rst_stb",   32'(stb), 32'd0);
        check("rst_we",    32'(we), 32'd0);
        check("rst_adr",   adr, 32'h100);
        check("rst_dat",   dat, 32'h0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("sel_const", 32'(sel), 32'hF);
        check("cti_const", 32'(cti), 32'd0);
        check("bte_const", 32'(bte), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("idle_cyc", 32'(cyc), 32'd0);

        // Always-ack slave: full frame, yield gaps, pattern words
        run_frame(0, NONE, NONE, -1);
        check("f1_timeout",   32'(timed_out), 32'd0);
        check("f1_first_req", 32'(first_ok), 32'd1);
        check("f1_acks",      32'(n_ack), 32'd32);
        check("f1_adr_seq",   32'(bad_adr), 32'd0);
        check("f1_last_adr",  last_adr, 32'h17C);
        check("f1_gap_cycles", 32'(gap_cyc), 32'd7);
        check("f1_gap_place", 32'(bad_gap), 32'd0);
        check("f1_done",      32'(fin_done), 32'd1);
        check("f1_error",     32'(fin_error), 32'd0);
        check("f1_after",     32'(extra), 32'd0);
        check("px_0_0",       dats[0],  32'h00FFFFFF);
        check("px_1_1",       dats[9],  32'h00010180);
        check("px_4_2",       dats[20], 32'h00FFFFFF);
        check("px_3_2",       dats[19], 32'h00030280);
        check("px_5_3",       dats[29], 32'h00050380);

        // Two wait states per ack, plus a start pulse mid-frame that must be ignored
        run_frame(2, NONE, NONE, 10);
        check("f2_timeout", 32'(timed_out), 32'd0);
        check("f2_acks",    32'(n_ack), 32'd32);
        check("f2_adr_seq", 32'(bad_adr), 32'd0);
        check("f2_stable",  32'(bad_stable), 32'd0);
        check("f2_done",    32'(fin_done), 32'd1);
`ifdef PATTERN_ANIM_EN
        check("f2_px_0_1",  dats[8], 32'h00010180);
`else
        check("f2_px_0_1",  dats[8], 32'h00FFFFFF);
`endif

        // Retry on the sixth request
        run_frame(0, 32'h114, NONE, -1);
        check("rty_timeout",  32'(timed_out), 32'd0);
        check("rty_reissue",  32'(rty_ok), 32'd1);
        check("rty_acks",     32'(n_ack), 32'd32);
        check("rty_adr_seq",  32'(bad_adr), 32'd0);
        check("rty_done",     32'(fin_done), 32'd1);

        // Error at 0x120
        run_frame(0, NONE, 32'h120, -1);
        check("err_timeout", 32'(timed_out), 32'd0);
        check("err_acks",    32'(n_ack), 32'd8);
        check("err_cyc",     32'(fin_cyc), 32'd0);
        check("err_flag",    32'(fin_error), 32'd1);
        check("err_no_done", 32'(fin_done), 32'd0);
        check("err_idle",    32'(extra), 32'd0);
        check("err_sticky",  32'(error), 32'd1);

        // New start clears the error and rewrites from the base
        run_frame(0, NONE, NONE, -1);
        check("clr_error",   32'(err_at_start), 32'd0);
        check("clr_first",   32'(first_ok), 32'd1);
        check("clr_acks",    32'(n_ack), 32'd32);
        check("clr_done",    32'(fin_done), 32'd1);
        check("clr_err_end", 32'(fin_error), 32'd0);

        // Reset in the middle of a frame
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (6) begin
            ack = cyc && stb;
            @(negedge sys_clk);
        end
        ack = 1'b0;
        check("mid_busy_pre", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_cyc",  32'(cyc), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(frame_done), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("mid_idle_cyc", 32'(cyc), 32'd0);

        // Full frame after reset; frame counter (if any) is back at zero
        run_frame(0, NONE, NONE, -1);
        check("post_first",  32'(first_ok), 32'd1);
        check("post_acks",   32'(n_ack), 32'd32);
        check("post_done",   32'(fin_done), 32'd1);
        check("post_px_0_1", dats[8], 32'h00FFFFFF);
        check("post_px_1_1", dats[9], 32'h00010180);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
